// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB-based branch predictor.
// The typedef and localparams describe the default geometry (32-bit PC, 64 entries).
package bp_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_ENTRIES    = 64;
  localparam int DEF_CNT_BITS   = 2;
  localparam int IDX_BITS       = $clog2(DEF_ENTRIES);
  localparam int TAG_BITS       = DEF_ADDR_WIDTH - IDX_BITS - 2;
  localparam int CNT_MAX_BITS   = 8;

  typedef struct packed {
    logic                      valid;
    logic                      is_jump;
    logic [TAG_BITS-1:0]       tag;
    logic [DEF_ADDR_WIDTH-1:0] target;
    logic [DEF_CNT_BITS-1:0]   cnt;
  } btb_entry_t;

  // Saturating step for a counter of 'bits' width (bits <= CNT_MAX_BITS).
  function automatic logic [CNT_MAX_BITS-1:0] cnt_next(input logic [CNT_MAX_BITS-1:0] cnt,
                                                        input logic taken,
                                                        input int unsigned bits);
    logic [CNT_MAX_BITS:0] max_v;
    max_v = ((CNT_MAX_BITS+1)'(1) << bits) - (CNT_MAX_BITS+1)'(1);
    if (taken) return (cnt == max_v[CNT_MAX_BITS-1:0]) ? cnt : cnt + 1'b1;
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update signals between the core and the predictor.
interface bp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int PERF_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PCF;
  logic                  PredTakenF;
  logic [ADDR_WIDTH-1:0] PredTargetF;
  logic                  UpdEnE;
  logic                  UpdIsJumpE;
  logic [ADDR_WIDTH-1:0] PCE;
  logic                  TakenE;
  logic [ADDR_WIDTH-1:0] TargetE;
  logic                  PredTakenE;
  logic [ADDR_WIDTH-1:0] PredTargetE;
  logic                  InvalidateAll;
  logic                  MispredictE;
  logic [ADDR_WIDTH-1:0] RedirectPCE;
  logic [PERF_WIDTH-1:0] PerfBranches;
  logic [PERF_WIDTH-1:0] PerfMispred;

  modport master (
    output PCF, UpdEnE, UpdIsJumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE, InvalidateAll,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, PerfBranches, PerfMispred
  );
  modport slave (
    input  PCF, UpdEnE, UpdIsJumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE, InvalidateAll,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, PerfBranches, PerfMispred
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter step used on the predictor's update port.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic                i_taken,
  output logic [CNT_BITS-1:0] o_cnt
);
  logic [CNT_MAX_BITS-1:0] w_next;

  assign w_next = cnt_next(CNT_MAX_BITS'(i_cnt), i_taken, CNT_BITS);
  assign o_cnt  = w_next[CNT_BITS-1:0];
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: same-cycle fetch prediction,
// execute-stage training, mispredict/redirect generation and perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int CNT_BITS   = 2,
  parameter int PERF_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  bp_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS-1);

  logic [ENTRIES-1:0]                 r_valid;
  logic [ENTRIES-1:0]                 r_jump;
  logic [ENTRIES-1:0][TAG_W-1:0]      r_tag;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] r_tgt;
  logic [ENTRIES-1:0][CNT_BITS-1:0]   r_cnt;
  logic [PERF_WIDTH-1:0]              r_perf_br;
  logic [PERF_WIDTH-1:0]              r_perf_mp;

  logic [IDX_W-1:0]    w_fidx, w_eidx;
  logic [TAG_W-1:0]    w_ftag, w_etag;
  logic                w_fhit, w_ehit, w_alloc, w_train, w_mispred;
  logic [CNT_BITS-1:0] w_cnt_nxt;

  // Fetch lookup reads the registered table, so a same-cycle update is not visible yet.
  assign w_fidx = bus.PCF[IDX_W+1:2];
  assign w_ftag = bus.PCF[ADDR_WIDTH-1:IDX_W+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

  assign bus.PredTakenF  = w_fhit && (r_jump[w_fidx] || r_cnt[w_fidx][CNT_BITS-1]);
  assign bus.PredTargetF = bus.PredTakenF ? r_tgt[w_fidx] : bus.PCF + ADDR_WIDTH'(4);

  assign w_eidx = bus.PCE[IDX_W+1:2];
  assign w_etag = bus.PCE[ADDR_WIDTH-1:IDX_W+2];
  assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);

  assign w_mispred = bus.UpdEnE &&
                     ((bus.TakenE != bus.PredTakenE) ||
                      (bus.TakenE && bus.PredTakenE && (bus.TargetE != bus.PredTargetE)));
  assign bus.MispredictE = w_mispred;
  assign bus.RedirectPCE = (bus.UpdEnE && bus.TakenE) ? bus.TargetE : bus.PCE + ADDR_WIDTH'(4);

  // Invalidate wins over a same-cycle update; not-taken misses never allocate.
  assign w_alloc = bus.UpdEnE && !bus.InvalidateAll && !w_ehit && bus.TakenE;
  assign w_train = bus.UpdEnE && !bus.InvalidateAll && w_ehit;

  sat_counter #(.CNT_BITS(CNT_BITS)) u_sat (
    .i_cnt   (r_cnt[w_eidx]),
    .i_taken (bus.TakenE),
    .o_cnt   (w_cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_cnt     <= '0;
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else begin
      r_perf_br <= r_perf_br + PERF_WIDTH'(bus.UpdEnE);
      r_perf_mp <= r_perf_mp + PERF_WIDTH'(w_mispred);
      if (bus.InvalidateAll) begin
        r_valid <= '0;
      end else if (w_alloc) begin
        r_valid[w_eidx] <= 1'b1;
        r_cnt[w_eidx]   <= CNT_WEAK;
      end else if (w_train) begin
        r_cnt[w_eidx]   <= w_cnt_nxt;
      end
    end
  end

  // Payload arrays are qualified by r_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_eidx]  <= w_etag;
      r_tgt[w_eidx]  <= bus.TargetE;
      r_jump[w_eidx] <= bus.UpdIsJumpE;
    end else if (w_train && bus.TakenE) begin
      r_tgt[w_eidx]  <= bus.TargetE;
    end
  end

  assign bus.PerfBranches = r_perf_br;
  assign bus.PerfMispred  = r_perf_mp;
endmodule
